// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//
// Multi-cycle sequencer that drives a 16-bit 181-style ALU.
// It takes one operation request at a time and runs one or more ALU passes:
//   - one pass for ADD/SUB/AND/OR/XOR/NOT
//   - two passes for ADD32 (low half, then high half with ripple carry)
//   - sixteen passes for MUL (shift-add)
// It returns a registered 32-bit result with carry/zero/negative/error flags.
//
// Ports:
//   clk, rst_n             clock and synchronous active-low reset
//   in_valid/in_ready      request handshake; in_ready is high only in IDLE
//   in_op, in_a, in_b      op code and operands, latched on accept
//   res_valid/res_ready    result handshake; result held while res_ready=0
//   res, res_c/z/n/err     32-bit result and flags
//   alu_a/b/s/m/cn         ALU control drive (cn is active-low carry-in)
//   alu_f/cf/zf            ALU result, active-low carry out, zero flag
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int W      = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     in_op,
    input  logic [2*W-1:0] in_a,
    input  logic [2*W-1:0] in_b,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*W-1:0] res,
    output logic           res_c,
    output logic           res_z,
    output logic           res_n,
    output logic           res_err,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [3:0]     alu_s,
    output logic           alu_m,
    output logic           alu_cn,
    input  logic [W-1:0]   alu_f,
    input  logic           alu_cf,
    input  logic           alu_zf
);

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_NOT   = 3'd5;
    localparam logic [2:0] OP_ADD32 = 3'd6;
    localparam logic [2:0] OP_MUL   = 3'd7;

    // ALU function selects used by this sequencer
    localparam logic [3:0] S_PLUS  = 4'b1001;
    localparam logic [3:0] S_MINUS = 4'b0110;
    localparam logic [3:0] S_AND   = 4'b1011;
    localparam logic [3:0] S_OR    = 4'b1110;
    localparam logic [3:0] S_XOR   = 4'b0110;
    localparam logic [3:0] S_NOTA  = 4'b0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_LO,
        ST_HI,
        ST_MUL,
        ST_DONE
    } state_t;

    state_t         state;
    logic [2:0]     op_q;
    logic [2*W-1:0] a_q;
    logic [2*W-1:0] b_q;

    // ADD32 low-pass state
    logic [W-1:0]   lo_q;
    logic           carry_q;
    logic           zf_lo_q;

    // shift-add multiplier state
    logic [W-1:0]   acc_hi;
    logic [W-1:0]   acc_lo;
    logic [W-1:0]   mcand;
    logic [3:0]     count;

    logic [2*W-1:0] mul_next;
    logic           exec_c;
    logic           exec_z;

    assign in_ready = (state == ST_IDLE);

    // Next multiplier accumulator: the ALU's carry out (active-low, hence
    // inverted) becomes the new top bit and the whole pair shifts right.
    always_comb begin
        mul_next = {~alu_cf, alu_f, acc_lo[W-1:1]};
    end

    // Single-pass flags. ADD reports carry (ALU carry is active-low), SUB
    // reports borrow directly. The ALU zero flag is only trusted in
    // arithmetic mode, so logic ops compare the result themselves.
    always_comb begin
        exec_c = 1'b0;
        if (op_q == OP_ADD) begin
            exec_c = ~alu_cf;
        end else if (op_q == OP_SUB) begin
            exec_c = alu_cf;
        end
        exec_z = alu_m ? (alu_f == '0) : alu_zf;
    end

    // ALU drive decoded from the current state and latched operands.
    // IDLE and DONE park the ALU in a harmless logic-mode setting.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_s  = S_NOTA;
        alu_m  = 1'b1;
        alu_cn = 1'b1;
        case (state)
            ST_EXEC: begin
                alu_a = a_q[W-1:0];
                alu_b = b_q[W-1:0];
                case (op_q)
                    OP_ADD: begin
                        alu_s = S_PLUS;
                        alu_m = 1'b0;
                    end
                    OP_SUB: begin
                        alu_s = S_MINUS;
                        alu_m = 1'b0;
                    end
                    OP_AND:  alu_s = S_AND;
                    OP_OR:   alu_s = S_OR;
                    OP_XOR:  alu_s = S_XOR;
                    OP_NOT:  alu_s = S_NOTA;
                    default: alu_s = S_NOTA;
                endcase
            end
            ST_LO: begin
                alu_a = a_q[W-1:0];
                alu_b = b_q[W-1:0];
                alu_s = S_PLUS;
                alu_m = 1'b0;
            end
            ST_HI: begin
                // registered low-pass CF: 0 means carry out, which is
                // exactly the active-low carry-in the high pass needs
                alu_a  = a_q[2*W-1:W];
                alu_b  = b_q[2*W-1:W];
                alu_s  = S_PLUS;
                alu_m  = 1'b0;
                alu_cn = carry_q;
            end
            ST_MUL: begin
                alu_a = acc_hi;
                alu_b = acc_lo[0] ? mcand : '0;
                alu_s = S_PLUS;
                alu_m = 1'b0;
            end
            default: begin
                alu_a  = '0;
                alu_b  = '0;
                alu_s  = S_NOTA;
                alu_m  = 1'b1;
                alu_cn = 1'b1;
            end
        endcase
    end

    // Main sequencer FSM with registered result and flags. Reset discards
    // any partial work, including an in-flight multiply.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            lo_q      <= '0;
            carry_q   <= 1'b1;
            zf_lo_q   <= 1'b0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            mcand     <= '0;
            count     <= '0;
            res       <= '0;
            res_c     <= 1'b0;
            res_z     <= 1'b0;
            res_n     <= 1'b0;
            res_err   <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q    <= in_op;
                        a_q     <= in_a;
                        b_q     <= in_b;
                        res_err <= 1'b0;
                        case (in_op)
                            OP_ADD32: state <= ST_LO;
                            OP_MUL: begin
                                if (MUL_EN) begin
                                    acc_hi <= '0;
                                    acc_lo <= in_a[W-1:0];
                                    mcand  <= in_b[W-1:0];
                                    count  <= '0;
                                    state  <= ST_MUL;
                                end else begin
                                    // unsupported: finish immediately
                                    res       <= '0;
                                    res_c     <= 1'b0;
                                    res_z     <= 1'b1;
                                    res_n     <= 1'b0;
                                    res_err   <= 1'b1;
                                    res_valid <= 1'b1;
                                    state     <= ST_DONE;
                                end
                            end
                            default: state <= ST_EXEC;
                        endcase
                    end
                end
                ST_EXEC: begin
                    res       <= {{W{1'b0}}, alu_f};
                    res_c     <= exec_c;
                    res_z     <= exec_z;
                    res_n     <= alu_f[W-1];
                    res_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_LO: begin
                    lo_q    <= alu_f;
                    carry_q <= alu_cf;
                    zf_lo_q <= alu_zf;
                    state   <= ST_HI;
                end
                ST_HI: begin
                    res       <= {alu_f, lo_q};
                    res_c     <= ~alu_cf;
                    res_z     <= zf_lo_q & alu_zf;
                    res_n     <= alu_f[W-1];
                    res_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_MUL: begin
                    {acc_hi, acc_lo} <= mul_next;
                    count            <= count + 4'd1;
                    if (count == 4'd15) begin
                        res       <= mul_next;
                        res_c     <= 1'b0;
                        res_z     <= (mul_next == '0);
                        res_n     <= mul_next[2*W-1];
                        res_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
